// File: rtl/cpu_pkg.sv
// cpu_pkg: shared FSM encoding, opcode classes and execute-latency helper
package cpu_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, CAPT = 2'd2, WB = 2'd3} state_t;
  localparam logic [3:0] OP_MUL = 4'hC;
  localparam logic [3:0] OP_DIV = 4'hD;
  function automatic int op_latency(input logic [31:0] op, input logic [31:0] op_mul,
                                    input logic [31:0] op_div, input int mul_cycles,
                                    input int div_cycles);
    return op == op_mul ? mul_cycles : op == op_div ? div_cycles : 1;
  endfunction
endpackage

// File: rtl/alu_exec_sequencer_arb.sv
// rr_arbiter2: two-input round-robin arbiter, favours the requester that did not win last
module rr_arbiter2 (
  input  logic [1:0] valid,
  input  logic       last,
  input  logic       enable,
  output logic [1:0] grant
);
  assign grant[0] = enable && valid[0] && (!valid[1] || last);
  assign grant[1] = enable && valid[1] && (!valid[0] || !last);
endmodule

// File: rtl/alu_exec_sequencer.sv
// alu_exec_sequencer: shares one multi-cycle ALU between two requesters, sequences exec/capture/writeback
module alu_exec_sequencer #(
  parameter int OPW = 4,
  parameter int RDW = 5,
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32,
  parameter logic [OPW-1:0] OP_MUL = OPW'(cpu_pkg::OP_MUL),
  parameter logic [OPW-1:0] OP_DIV = OPW'(cpu_pkg::OP_DIV)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [OPW-1:0] req0_op,
  input  logic [RDW-1:0] req0_rd,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [OPW-1:0] req1_op,
  input  logic [RDW-1:0] req1_rd,
  input  logic           flush,
  output logic [OPW-1:0] alu_op,
  output logic           alu_start,
  output logic           alu_out_write,
  output logic           wb_valid,
  input  logic           wb_ready,
  output logic [RDW-1:0] wb_rd,
  output logic           wb_src,
  output logic           busy
);
  import cpu_pkg::*;
  localparam int MAXC = MUL_CYCLES > DIV_CYCLES ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW = MAXC > 1 ? $clog2(MAXC) : 1;
  state_t state, next;
  logic [CW-1:0] cnt, acc_cnt, first_cnt;
  logic [OPW-1:0] op_q, acc_op;
  logic [RDW-1:0] rd_q;
  logic src_q, rr_last, acc;
  logic [1:0] grant;
  rr_arbiter2 u_arb (
    .valid  ({req1_valid, req0_valid}),
    .last   (rr_last),
    .enable (state == IDLE && !flush),
    .grant  (grant)
  );
  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign acc = |grant;
  assign acc_op = grant[1] ? req1_op : req0_op;
  assign acc_cnt = CW'(op_latency(32'(acc_op), 32'(OP_MUL), 32'(OP_DIV), MUL_CYCLES, DIV_CYCLES) - 1);
  // cnt still holds its load value only on the first EXEC cycle
  assign first_cnt = CW'(op_latency(32'(op_q), 32'(OP_MUL), 32'(OP_DIV), MUL_CYCLES, DIV_CYCLES) - 1);
  always_comb begin
    next = state;
    unique case (state)
      IDLE: next = acc ? EXEC : IDLE;
      EXEC: next = flush ? IDLE : cnt == '0 ? CAPT : EXEC;
      CAPT: next = flush ? IDLE : WB;
      WB:   next = flush || wb_ready ? IDLE : WB;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      op_q <= '0;
      rd_q <= '0;
      src_q <= 1'b0;
      rr_last <= 1'b1;
    end else begin
      state <= next;
      if (acc) begin
        op_q <= acc_op;
        rd_q <= grant[1] ? req1_rd : req0_rd;
        src_q <= grant[1];
        rr_last <= grant[1];
        cnt <= acc_cnt;
      end else if (state == EXEC && cnt != '0) begin
        cnt <= cnt - CW'(1);
      end
    end
  end
  assign alu_op = op_q;
  assign alu_start = state == EXEC && cnt == first_cnt;
  assign alu_out_write = state == CAPT && !flush;
  assign wb_valid = state == WB && !flush;
  assign wb_rd = rd_q;
  assign wb_src = src_q;
  assign busy = state != IDLE;
endmodule

// File: tb/tb_alu_exec_sequencer.sv
// tb_alu_exec_sequencer: directed table, corner-case sequences and a randomized transaction-level model
module tb_alu_exec_sequencer;
  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 32;
  logic clk, rst_n;
  logic req0_valid, req0_ready, req1_valid, req1_ready, flush;
  logic [3:0] req0_op, req1_op, alu_op;
  logic [4:0] req0_rd, req1_rd, wb_rd;
  logic alu_start, alu_out_write, wb_valid, wb_ready, wb_src, busy;
  int checks = 0;
  int errors = 0;
  alu_exec_sequencer dut (
    .clk(clk), .reset(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_rd(req0_rd),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_rd(req1_rd),
    .flush(flush), .alu_op(alu_op), .alu_start(alu_start), .alu_out_write(alu_out_write),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_src(wb_src), .busy(busy)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  typedef struct {
    bit         src;
    logic [3:0] op;
    logic [4:0] rd;
    int         exp_wb;
  } vec_t;
  vec_t tbl[6];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic chk_zero(input string nm);
    chk(nm, 32'({alu_op, alu_start, alu_out_write, wb_valid, wb_rd, wb_src, busy}), 0);
  endtask
  task automatic wait_idle();
    int i;
    i = 0;
    #1;
    while (busy && i < 100) begin
      @(negedge clk);
      #1;
      i++;
    end
    chk("idle_reached", 32'(busy), 0);
  endtask
  task automatic run_op(input bit src, input logic [3:0] op, input logic [4:0] rd, input int exp_wb);
    int wb_at, writes;
    wb_at = -1;
    writes = 0;
    @(negedge clk);
    req0_valid = !src; req1_valid = src;
    req0_op = op; req1_op = op; req0_rd = rd; req1_rd = rd;
    wb_ready = 1'b1; flush = 1'b0;
    #1 chk("run_ready", 32'(src ? req1_ready : req0_ready), 1);
    for (int c = 1; c < 80 && wb_at < 0; c++) begin
      @(negedge clk);
      req0_valid = 1'b0; req1_valid = 1'b0;
      #1;
      writes += int'(alu_out_write);
      if (wb_valid) begin
        wb_at = c;
        chk("run_wb_rd", 32'(wb_rd), 32'(rd));
        chk("run_wb_src", 32'(wb_src), 32'(src));
        chk("run_alu_op", 32'(alu_op), 32'(op));
      end
    end
    chk("run_wb_latency", 32'(wb_at), 32'(exp_wb));
    chk("run_writes", 32'(writes), 1);
    @(negedge clk);
    #1 chk("run_idle", 32'(busy), 0);
  endtask
  initial begin
    int n, writes, wbs;
    bit exp_g;
    bit m_busy, m_src, m_last, g, e_r0, e_r1, e_start, e_wr, e_wbv;
    int k, m_lat;
    logic [3:0] m_op;
    logic [4:0] m_rd;
    tbl[0] = '{0, 4'h1, 5'd3, 3};
    tbl[1] = '{1, 4'hC, 5'd17, MUL_LAT + 2};
    tbl[2] = '{0, 4'hD, 5'd31, DIV_LAT + 2};
    tbl[3] = '{1, 4'h0, 5'd0, 3};
    tbl[4] = '{0, 4'hF, 5'd8, 3};
    tbl[5] = '{1, 4'hB, 5'd22, 3};
    req0_valid = 0; req1_valid = 0; req0_op = 0; req1_op = 0; req0_rd = 0; req1_rd = 0;
    flush = 0; wb_ready = 0; rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1 chk_zero("reset_outputs");
    chk("reset_ready", 32'({req0_ready, req1_ready}), 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    // basic single-cycle timeline from req0
    @(negedge clk);
    req0_valid = 1; req0_op = 4'h1; req0_rd = 5'd3; wb_ready = 1;
    #1 chk("t0_ready", 32'({req1_ready, req0_ready}), 1);
    @(negedge clk); req0_valid = 0;
    #1 chk("t1_start_write_busy", 32'({alu_start, alu_out_write, busy}), 3'b101);
    chk("t1_alu_op", 32'(alu_op), 1);
    @(negedge clk);
    #1 chk("t2_start_write", 32'({alu_start, alu_out_write, wb_valid}), 3'b010);
    @(negedge clk);
    #1 chk("t3_wb", 32'({alu_out_write, wb_valid, wb_rd, wb_src}), {1'b0, 1'b1, 5'd3, 1'b0});
    @(negedge clk);
    #1 chk("t4_busy", 32'(busy), 0);
    // alternating grants with both requesters pending
    @(negedge clk);
    req0_valid = 1; req1_valid = 1; req0_op = 1; req1_op = 1; req0_rd = 1; req1_rd = 2; wb_ready = 1;
    exp_g = 1; n = 0;
    for (int c = 0; c < 60 && n < 4; c++) begin
      #1 chk("alt_one_hot", 32'(req0_ready && req1_ready), 0);
      if (req0_ready || req1_ready) begin
        chk("alt_grant", 32'(req1_ready), 32'(exp_g));
        exp_g = !exp_g;
        n++;
      end
      @(negedge clk);
    end
    req0_valid = 0; req1_valid = 0;
    chk("alt_count", 32'(n), 4);
    wait_idle();
    // multiply from req1
    @(negedge clk);
    req1_valid = 1; req1_op = 4'hC; req1_rd = 5'd7; wb_ready = 1;
    #1 chk("mul_ready", 32'(req1_ready), 1);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk); req1_valid = 0;
      #1 chk("mul_start", 32'(alu_start), 32'(c == 1));
      chk("mul_write", 32'(alu_out_write), 32'(c == 5));
      chk("mul_wb_valid", 32'(wb_valid), 32'(c == 6));
      chk("mul_alu_op", 32'(alu_op), 32'hC);
    end
    chk("mul_wb", 32'({wb_rd, wb_src}), {5'd7, 1'b1});
    @(negedge clk);
    #1 chk("mul_idle", 32'(busy), 0);
    // writeback stall
    @(negedge clk);
    req0_valid = 1; req0_op = 4'h2; req0_rd = 5'd9; wb_ready = 0;
    #1 chk("stall_ready", 32'(req0_ready), 1);
    @(negedge clk); req0_valid = 0;
    @(negedge clk);
    for (int c = 3; c <= 12; c++) begin
      @(negedge clk);
      req0_valid = 1; req1_valid = 1;
      #1 chk("stall_wb", 32'({wb_valid, wb_rd, wb_src}), {1'b1, 5'd9, 1'b0});
      chk("stall_no_ready", 32'({req0_ready, req1_ready}), 0);
    end
    @(negedge clk);
    req0_valid = 0; req1_valid = 0; wb_ready = 1;
    #1 chk("stall_release_valid", 32'(wb_valid), 1);
    @(negedge clk);
    #1 chk("stall_idle", 32'(busy), 0);
    // flush in third EXEC cycle of a divide
    @(negedge clk);
    req0_valid = 1; req0_op = 4'hD; req0_rd = 5'd4; wb_ready = 1;
    #1 chk("div_ready", 32'(req0_ready), 1);
    writes = 0; wbs = 0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      req0_valid = 0; flush = (c == 3);
      #1 writes += int'(alu_out_write);
      wbs += int'(wb_valid);
    end
    @(negedge clk); flush = 0;
    #1 chk("div_flush_idle", 32'(busy), 0);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      #1 writes += int'(alu_out_write);
      wbs += int'(wb_valid);
    end
    chk("div_flush_writes", 32'(writes), 0);
    chk("div_flush_wb", 32'(wbs), 0);
    run_op(1, 4'h3, 5'd1, 3);
    // async reset in CAPT
    @(negedge clk);
    req0_valid = 1; req0_op = 4'h5; req0_rd = 5'd12; wb_ready = 1;
    @(negedge clk); req0_valid = 0;
    @(negedge clk);
    #1 chk("capt_write", 32'(alu_out_write), 1);
    #2 rst_n = 1'b0;
    #1 chk_zero("async_reset_outputs");
    @(negedge clk); rst_n = 1'b1;
    req0_valid = 1; req1_valid = 1; req0_op = 1; req1_op = 1;
    #1 chk("reset_tie", 32'({req1_ready, req0_ready}), 2'b01);
    @(negedge clk); req0_valid = 0; req1_valid = 0;
    wait_idle();
    // directed table
    foreach (tbl[i]) run_op(tbl[i].src, tbl[i].op, tbl[i].rd, tbl[i].exp_wb);
    // randomized against transaction-level model
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    m_busy = 0; m_last = 1; k = 0; m_lat = 1; m_op = 0; m_rd = 0; m_src = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      req0_valid = 1'($urandom_range(0, 1));
      req1_valid = 1'($urandom_range(0, 1));
      req0_op = $urandom_range(0, 3) == 0 ? ($urandom_range(0, 1) ? 4'hC : 4'hD) : 4'($urandom_range(0, 15));
      req1_op = $urandom_range(0, 3) == 0 ? ($urandom_range(0, 1) ? 4'hC : 4'hD) : 4'($urandom_range(0, 15));
      req0_rd = 5'($urandom_range(0, 31));
      req1_rd = 5'($urandom_range(0, 31));
      flush = $urandom_range(0, 19) == 0;
      wb_ready = $urandom_range(0, 9) < 6;
      g = req0_valid && req1_valid ? !m_last : req1_valid;
      e_r0 = !m_busy && !flush && req0_valid && !g;
      e_r1 = !m_busy && !flush && req1_valid && g;
      e_start = m_busy && k == 1;
      e_wr = m_busy && k == m_lat + 1 && !flush;
      e_wbv = m_busy && k >= m_lat + 2 && !flush;
      #1 chk("rnd_ready", 32'({req1_ready, req0_ready}), 32'({e_r1, e_r0}));
      chk("rnd_ctrl", 32'({alu_start, alu_out_write, wb_valid, busy}), 32'({e_start, e_wr, e_wbv, m_busy}));
      if (m_busy) chk("rnd_alu_op", 32'(alu_op), 32'(m_op));
      if (e_wbv) chk("rnd_wb", 32'({wb_rd, wb_src}), 32'({m_rd, m_src}));
      if (m_busy) begin
        if (flush || (k >= m_lat + 2 && wb_ready)) m_busy = 0;
        else k++;
      end else if (e_r0 || e_r1) begin
        m_busy = 1; k = 1; m_src = e_r1; m_last = e_r1;
        m_op = e_r1 ? req1_op : req0_op;
        m_rd = e_r1 ? req1_rd : req0_rd;
        m_lat = m_op == 4'hC ? MUL_LAT : m_op == 4'hD ? DIV_LAT : 1;
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_exec_sequencer.md
Name: alu_exec_sequencer

Overview:
- Multi-cycle execute-stage controller that shares one ALU and its 32-bit ALU output register between two requesters: req0 (instruction execute) and req1 (address generation).
- Round-robin arbitration; each granted op is sequenced through execute (1 or N cycles), capture and writeback.
- Drives the output register's write enable and hands the captured result to register-file writeback with a valid/ready handshake.

Parameters:
- OPW, 4, ALU opcode width
- RDW, 5, destination register index width
- MUL_CYCLES, 4, execute latency of MUL op (>=1)
- DIV_CYCLES, 32, execute latency of DIV op (>=1)
- OP_MUL, 4'hC, opcode classed as multiply
- OP_DIV, 4'hD, opcode classed as divide

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- req0_valid  in  1  requester 0 has an op
- req0_ready  out  1  requester 0 op accepted this cycle
- req0_op  in  OPW  requester 0 opcode
- req0_rd  in  RDW  requester 0 destination
- req1_valid / req1_ready / req1_op / req1_rd  same as req0, for requester 1
- flush  in  1  abort current op
- alu_op  out  OPW  opcode driven to ALU
- alu_start  out  1  one-cycle pulse, first EXEC cycle
- alu_out_write  out  1  write enable to ALU output register
- wb_valid  out  1  captured result ready for writeback
- wb_ready  in  1  writeback accepts
- wb_rd  out  RDW  writeback destination
- wb_src  out  1  requester id of the op in flight
- busy  out  1  state != IDLE

Behaviour:
- States: IDLE, EXEC, CAPT, WB. Encoding comes from the shared package.
- Reset (asserted low, async):
  - state=IDLE, cnt=0, rr_last=1 (req0 wins first).
  - alu_op=0, alu_start=0, alu_out_write=0, wb_valid=0, wb_rd=0, wb_src=0, busy=0.
- Arbitration, IDLE only:
  - If only one valid, grant it.
  - If both valid, grant the requester != rr_last.
  - reqN_ready = (state==IDLE) && grantN && !flush. At most one ready per cycle; readys are combinational from valids.
- Accept (valid&&ready at edge T):
  - Latch op, rd, src. Set rr_last=src.
  - Load cnt = latency-1, where latency = MUL_CYCLES if op==OP_MUL, DIV_CYCLES if op==OP_DIV, else 1.
  - Go to EXEC.
- EXEC:
  - alu_op = latched op, held stable for the whole op through WB.
  - alu_start=1 on the first EXEC cycle only.
  - cnt!=0: decrement, stay. cnt==0: go to CAPT.
- CAPT:
  - alu_out_write=1 for exactly one cycle, then go to WB.
  - Single-cycle op timeline: accept T, EXEC T+1, CAPT T+2, wb_valid from T+3. Total accept-to-wb_valid = latency+2 cycles.
- WB:
  - wb_valid=1; wb_rd and wb_src are stable while wb_valid is high.
  - Hold until wb_ready. On the wb_valid&&wb_ready edge go to IDLE; a new accept is possible the following cycle.
  - Back-to-back ops are not overlapped.
- flush:
  - In EXEC or CAPT: go to IDLE next edge; alu_out_write is not asserted after the flush cycle (flush in CAPT suppresses the write that cycle).
  - In WB: drop wb_valid and go to IDLE.
  - In IDLE: no accept that cycle.
  - rr_last is unchanged by flush.
- Simultaneous wb_ready and flush in WB: flush wins (no handshake counted); go to IDLE either way.
- Valid dropped by a requester before ready: no effect; no state is held for unaccepted requests.
- Reset mid-op: immediate return to the reset values; no alu_out_write pulse.
- Counter width: clog2(max(MUL_CYCLES,DIV_CYCLES)); saturation is never reached.

Decomposition:
- Shared package (cpu_pkg) holds:
  - state enum / localparams IDLE=2'd0, EXEC=2'd1, CAPT=2'd2, WB=2'd3
  - OP_MUL, OP_DIV opcode constants
  - function op_latency(op) returning execute cycles
- One natural sub-module: rr_arbiter2 (2-input round-robin, inputs valid[1:0], last, enable; output grant[1:0]).
- FSM, counter and output decode stay in the top.

Test Plan:
- After reset release, req0 valid op=4'h1 rd=3, wb_ready=1 -> req0_ready at T, alu_start T+1, alu_out_write T+2 only, wb_valid T+3 with wb_rd=3 wb_src=0, busy low T+4.
- Both valid continuously, single-cycle ops -> grants alternate 0,1,0,1; never two readys in one cycle.
- req1 op=OP_MUL, MUL_CYCLES=4 -> EXEC 4 cycles, alu_out_write at T+5, wb_valid at T+6; alu_op=4'hC stable T+1..WB exit.
- wb_ready held low 10 cycles in WB -> wb_valid, wb_rd, wb_src stable; no new ready; IDLE one cycle after wb_ready rises.
- flush in 3rd EXEC cycle of OP_DIV -> IDLE next edge, zero alu_out_write pulses, wb_valid never asserted; next op accepted normally.
- reset asserted low asynchronously during CAPT -> all outputs 0 immediately; after release req0 wins tie.
